// File: rtl/iir_cascade_sched.sv
// Time-multiplexed direct-form-I biquad cascade with one shared 24x18 MAC.
// Coefficients come from external memory; per-section delay state is internal.
module iir_cascade_sched #(
  parameter int NUM_SECTIONS = 2,
  parameter int COEF_AW      = 4
) (
  input  logic                clk,
  input  logic                i_rst_n,
  input  logic                lrclk_posedge,
  input  logic                i_valid,
  input  logic [15:0]         x_in,
  output logic [COEF_AW-1:0]  o_coef_addr,
  input  logic [17:0]         i_coef_data,
  output logic [23:0]         audio_out,
  output logic                o_out_valid,
  output logic                o_busy,
  output logic                o_overrun,
  output logic                o_sat
);

  localparam int SW = (NUM_SECTIONS > 1) ? $clog2(NUM_SECTIONS) : 1;

  typedef enum logic [2:0] {
    IDLE, FETCH, MAC, WB, DONE
  } state_t;

  state_t state_q, state_d;

  logic [2:0]         t_q;
  logic [SW-1:0]      s_q;
  logic signed [23:0] in_q;
  logic signed [47:0] acc_q;

  logic signed [23:0] x1_q [NUM_SECTIONS];
  logic signed [23:0] x2_q [NUM_SECTIONS];
  logic signed [23:0] y1_q [NUM_SECTIONS];
  logic signed [23:0] y2_q [NUM_SECTIONS];

  logic signed [23:0] op;
  logic signed [41:0] prod;
  logic signed [47:0] y_raw;
  logic signed [23:0] y;
  logic               sat_hi, sat_lo;
  logic               last, start;

  assign start = lrclk_posedge & i_valid;
  assign last  = (s_q == SW'(NUM_SECTIONS - 1));

  always_comb begin
    op = in_q;
    unique case (t_q)
      3'd0:    op = in_q;
      3'd1:    op = x1_q[s_q];
      3'd2:    op = x2_q[s_q];
      3'd3:    op = y1_q[s_q];
      default: op = y2_q[s_q];
    endcase
  end

  assign prod   = $signed(i_coef_data) * op;
  assign y_raw  = acc_q >>> 16;
  assign sat_hi = y_raw > 48'sd8388607;
  assign sat_lo = y_raw < -48'sd8388608;

  always_comb begin
    y = y_raw[23:0];
    if (sat_hi) y = 24'sh7FFFFF;
    if (sat_lo) y = 24'sh800000;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = FETCH;
      FETCH:   state_d = MAC;
      MAC:     if (t_q == 3'd4) state_d = WB;
      WB:      state_d = last ? DONE : FETCH;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (!i_valid) state_d = IDLE;
  end

  assign o_busy      = (state_q != IDLE);
  assign o_out_valid = (state_q == DONE);

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      t_q         <= '0;
      s_q         <= '0;
      in_q        <= '0;
      acc_q       <= '0;
      o_coef_addr <= '0;
      audio_out   <= '0;
      o_overrun   <= 1'b0;
      o_sat       <= 1'b0;
      for (int i = 0; i < NUM_SECTIONS; i++) begin
        x1_q[i] <= '0;
        x2_q[i] <= '0;
        y1_q[i] <= '0;
        y2_q[i] <= '0;
      end
    end else if (!i_valid) begin
      // Abort: drop the sample in flight and forget all history.
      state_q   <= IDLE;
      audio_out <= '0;
      o_overrun <= 1'b0;
      o_sat     <= 1'b0;
      for (int i = 0; i < NUM_SECTIONS; i++) begin
        x1_q[i] <= '0;
        x2_q[i] <= '0;
        y1_q[i] <= '0;
        y2_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (lrclk_posedge && state_q != IDLE) o_overrun <= 1'b1;
      unique case (state_q)
        IDLE: begin
          if (lrclk_posedge) begin
            in_q        <= {x_in, 8'h00};
            s_q         <= '0;
            o_coef_addr <= '0;
          end
        end
        FETCH: begin
          acc_q       <= '0;
          t_q         <= '0;
          o_coef_addr <= o_coef_addr + COEF_AW'(1);
        end
        MAC: begin
          acc_q <= acc_q + {{6{prod[41]}}, prod};
          t_q   <= t_q + 3'd1;
          if (t_q < 3'd3) o_coef_addr <= o_coef_addr + COEF_AW'(1);
        end
        WB: begin
          x2_q[s_q] <= x1_q[s_q];
          x1_q[s_q] <= in_q;
          y2_q[s_q] <= y1_q[s_q];
          y1_q[s_q] <= y;
          in_q      <= y;
          if (sat_hi || sat_lo) o_sat <= 1'b1;
          if (last) begin
            audio_out <= y;
          end else begin
            s_q         <= s_q + SW'(1);
            o_coef_addr <= COEF_AW'(5 * (32'(s_q) + 1));
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/iir_cascade_sched.md
Name: iir_cascade_sched

Overview:
- Time-multiplexed biquad cascade engine for the audio filter path.
- On each sample strobe it sequences one shared 24x18 multiply-accumulate through NUM_SECTIONS direct-form-I biquad sections.
- Coefficients are fetched from an external coefficient memory; per-section delay state is held internally.
- Sits between the I2S receive sample and the audio output mux, replacing one fixed-function biquad per section.

Parameters:
NUM_SECTIONS, 2, number of cascaded biquad sections (1..8)
COEF_AW, 4, coefficient address width; must satisfy 2^COEF_AW >= 5*NUM_SECTIONS

Ports:
clk  input  1  system clock
i_rst_n  input  1  asynchronous active-low reset
lrclk_posedge  input  1  one-cycle sample strobe
i_valid  input  1  filter enable; low = synchronous clear/abort
x_in  input  16  signed input sample, stable while strobe high
o_coef_addr  output  COEF_AW  coefficient read address
i_coef_data  input  18  signed Q2.16 coefficient, valid one cycle after address
audio_out  output  24  signed filtered result (Q16.8, i.e. x_in<<8 scale)
o_out_valid  output  1  one-cycle pulse when audio_out updates
o_busy  output  1  high while a sample is being processed
o_overrun  output  1  sticky: strobe arrived while busy
o_sat  output  1  sticky: any section output saturated

Behaviour:
- Clock and reset: one clock clk; reset i_rst_n is asynchronous, active-low.
- Reset values: all outputs 0; state IDLE; all delay registers 0.
- Coefficient map: address = 5*s + t, with t = 0:b1, 1:b2, 2:b3, 3:a2, 4:a3.
- Feedback coefficients are stored pre-negated. All five products are added.
- Section s input:
  - s = 0: {x_in, 8'b0}, sign-extended to 24 bits, latched on strobe.
  - s > 0: y of section s-1 for the current sample.
- Per-section state: x1, x2, y1, y2, each 24-bit signed.
- Accumulator:
  - 48-bit signed, cleared at each section start.
  - acc = b1*in + b2*x1 + b3*x2 + a2*y1 + a3*y2.
  - Each product is 42-bit, sign-extended into the accumulator.
- Section output: y = acc >>> 16, clamped to [-8388608, 8388607]. Clamping sets o_sat.
- States:
  - IDLE: on lrclk_posedge & i_valid, latch x_in, s = 0, go to FETCH.
  - FETCH (1 cycle): o_coef_addr = 5s.
  - MAC0..MAC4 (5 cycles): accumulate i_coef_data times operand t. During MACt (t<4), o_coef_addr = 5s+t+1.
  - WB (1 cycle): compute y, then x2<=x1, x1<=in, y2<=y1, y1<=y. If s < NUM_SECTIONS-1, s++ and go to FETCH; else go to DONE.
  - DONE (1 cycle): audio_out <= y of last section, o_out_valid = 1, go to IDLE.
- Latency:
  - Strobe sampled in cycle 0.
  - Section s occupies cycles 1+7s .. 7+7s.
  - o_out_valid is high in cycle 7*NUM_SECTIONS+1 (cycle 15 for N=2).
- o_busy: high in every state except IDLE.
- o_coef_addr: holds its last value in IDLE.
- Overrun: strobe while o_busy=1 is ignored; the current computation continues and o_overrun sets.
- Strobe in the DONE cycle also counts as overrun.
- i_valid low, any state (including mid-computation):
  - Next edge: state IDLE; all delay registers, audio_out, o_overrun and o_sat cleared.
  - No o_out_valid is produced for the aborted sample.
- Strobe with i_valid low: ignored.
- Sticky flags clear only via reset or i_valid low.

Test Plan:
- Passthrough, N=2: both sections b1 = 65536, others 0; x_in = 1000 -> o_out_valid at cycle 15, audio_out = 256000, o_sat = 0.
- Delay: section0 b2 = 65536 (others 0), section1 passthrough; samples 100, 200 -> audio_out 0, then 25600.
- Feedback: section0 b1 = 65536, a2 = 32768; section1 passthrough; impulse x = 1000, then zeros -> audio_out 256000, 128000, 64000, 32000.
- Saturation: section0 b1 = 131071; x_in = 32767 -> audio_out = 8388607, o_sat = 1 and held across later samples.
- Overrun: second strobe at cycle 5 after the first -> o_overrun = 1, first result unchanged at cycle 15, no second o_out_valid.
- Abort: drop i_valid at cycle 8 -> o_busy = 0 at the next edge, no o_out_valid. Re-enable passthrough with x = 10 -> audio_out = 2560 (delay state cleared).
